// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter: write FIFO, 16x baud generator, runtime parity/stop modes; UART_TX_BREAK_EN adds Tx_BREAK.
// Write-to-TxD latency 2 clocks; no backpressure, writes while full or disabled are dropped.
module uart_tx_fifo_param #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_HZ     = 50000000,
  parameter int LSB_FIRST  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Tx_EN,
  input  logic                        Tx_WR,
  input  logic [DATA_BITS-1:0]        Tx_DATA,
  input  logic [2:0]                  baud_select,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop_bits,
`ifdef UART_TX_BREAK_EN
  input  logic                        Tx_BREAK,
`endif
  output logic                        TxD,
  output logic                        Tx_BUSY,
  output logic                        Tx_FULL,
  output logic                        Tx_EMPTY,
  output logic [$clog2(FIFO_DEPTH):0] Tx_LEVEL
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  function automatic int calc_div(input int rate);
    longint c;
    longint r;
    c = longint'(CLK_HZ);
    r = longint'(rate);
    return int'((c + 8 * r) / (16 * r));
  endfunction

  localparam int DW = $clog2(calc_div(300) + 1);
  localparam logic [DW-1:0] DM0 = DW'(calc_div(300) - 1);
  localparam logic [DW-1:0] DM1 = DW'(calc_div(1200) - 1);
  localparam logic [DW-1:0] DM2 = DW'(calc_div(4800) - 1);
  localparam logic [DW-1:0] DM3 = DW'(calc_div(9600) - 1);
  localparam logic [DW-1:0] DM4 = DW'(calc_div(19200) - 1);
  localparam logic [DW-1:0] DM5 = DW'(calc_div(38400) - 1);
  localparam logic [DW-1:0] DM6 = DW'(calc_div(57600) - 1);
  localparam logic [DW-1:0] DM7 = DW'(calc_div(115200) - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] S_BREAK  = 3'd5;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          level_q, level_d;
  logic [2:0]           state_q, state_d;
  logic [DW-1:0]        cnt_q, cnt_d, dmax_q, dmax_d, dmax_sel;
  logic [3:0]           tick_q, tick_d, bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head;
  logic                 par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic                 txd_q, txd_d, busy_q, busy_d;
  logic                 push, pop, brk_go, tick, bit_end, data_bit;
`ifdef UART_TX_BREAK_EN
  logic [3:0]           brk_len_q, brk_len_d;
`endif

`ifdef UART_TX_BREAK_EN
  assign brk_go = (state_q == S_IDLE) && Tx_BREAK;
`else
  assign brk_go = 1'b0;
`endif

  assign head     = mem_q[rd_ptr_q];
  assign push     = Tx_WR && Tx_EN && !Tx_FULL;
  assign pop      = (state_q == S_IDLE) && (level_q != '0) && Tx_EN && !brk_go;
  assign tick     = (cnt_q == dmax_q);
  assign bit_end  = tick && (tick_q == 4'hF);
  assign data_bit = (LSB_FIRST != 0) ? shift_q[0] : shift_q[DATA_BITS-1];

  assign TxD      = txd_q;
  assign Tx_BUSY  = busy_q;
  assign Tx_FULL  = (level_q == DEPTH_L);
  assign Tx_EMPTY = (level_q == '0);
  assign Tx_LEVEL = level_q;

  always_comb begin
    case (baud_select)
      3'd0:    dmax_sel = DM0;
      3'd1:    dmax_sel = DM1;
      3'd2:    dmax_sel = DM2;
      3'd3:    dmax_sel = DM3;
      3'd4:    dmax_sel = DM4;
      3'd5:    dmax_sel = DM5;
      3'd6:    dmax_sel = DM6;
      default: dmax_sel = DM7;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    dmax_d    = dmax_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
`ifdef UART_TX_BREAK_EN
    brk_len_d = brk_len_q;
`endif
    // Baud divider and tick counter only run while a frame is on the line
    if (state_q == S_IDLE) begin
      cnt_d  = '0;
      tick_d = '0;
    end else begin
      cnt_d  = tick ? '0 : cnt_q + 1'b1;
      tick_d = tick ? tick_q + 1'b1 : tick_q;
    end
    case (state_q)
      S_IDLE: begin
        if (pop || brk_go) begin
          dmax_d    = dmax_sel;
          par_en_d  = (parity_mode != 2'b00);
          par_bit_d = (parity_mode == 2'b01) ? ^head :
                      (parity_mode == 2'b10) ? ~^head : 1'b0;
          stop2_d   = stop_bits;
          shift_d   = head;
          bit_d     = '0;
          state_d   = S_START;
`ifdef UART_TX_BREAK_EN
          brk_len_d = 4'(1 + DATA_BITS) + {3'b000, parity_mode != 2'b00} + (stop_bits ? 4'd2 : 4'd1);
          if (brk_go) state_d = S_BREAK;
`endif
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_q == 4'd0)) bit_d = 4'd1;
          else                            state_d = S_IDLE;
        end
      end
`ifdef UART_TX_BREAK_EN
      // Hold the line low for at least one frame, then release on a bit boundary
      S_BREAK: begin
        if (bit_end) begin
          if (bit_q != 4'hF) bit_d = bit_q + 1'b1;
          if ((bit_q >= brk_len_q - 1'b1) && !Tx_BREAK) begin
            bit_d   = '0;
            stop2_d = 1'b0;
            state_d = S_STOP;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = data_bit;
      S_PARITY: txd_d = par_bit_q;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  txd_d = 1'b0;
`endif
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      dmax_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_len_q <= '0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q   <= level_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      dmax_q    <= dmax_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
`ifdef UART_TX_BREAK_EN
      brk_len_q <= brk_len_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= Tx_DATA;
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: MSB-first and LSB-first instances share all inputs.
module tb_uart_tx_fifo_param;

  logic       clk;
  logic       reset;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic [2:0] baud_select;
  logic [1:0] parity_mode;
  logic       stop_bits;
`ifdef UART_TX_BREAK_EN
  logic       Tx_BREAK;
`endif
  logic       txd0, busy0, full0, empty0;
  logic [2:0] level0;
  logic       txd1, busy1, full1, empty1;
  logic [2:0] level1;

  int n_checks = 0;
  int n_fails  = 0;

  uart_tx_fifo_param #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLK_HZ(50000000), .LSB_FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA),
    .baud_select(baud_select), .parity_mode(parity_mode), .stop_bits(stop_bits),
`ifdef UART_TX_BREAK_EN
    .Tx_BREAK(Tx_BREAK),
`endif
    .TxD(txd0), .Tx_BUSY(busy0), .Tx_FULL(full0), .Tx_EMPTY(empty0), .Tx_LEVEL(level0)
  );

  uart_tx_fifo_param #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLK_HZ(50000000), .LSB_FIRST(1)) dut1 (
    .clk(clk), .reset(reset), .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA),
    .baud_select(baud_select), .parity_mode(parity_mode), .stop_bits(stop_bits),
`ifdef UART_TX_BREAK_EN
    .Tx_BREAK(Tx_BREAK),
`endif
    .TxD(txd1), .Tx_BUSY(busy1), .Tx_FULL(full1), .Tx_EMPTY(empty1), .Tx_LEVEL(level1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] d);
    Tx_WR   = 1'b1;
    Tx_DATA = d;
    cycles(1);
    Tx_WR   = 1'b0;
  endtask

  // Waits for a frame (bounded), samples bit centres at 432-clock spacing, measures busy/low time.
  task automatic capture(input int nbits, output logic [15:0] b0, output logic [15:0] b1,
                         output int gap, output int blen, output int nlow, output logic [2:0] lvl);
    gap = 0; blen = 0; nlow = 0; b0 = '0; b1 = '0;
    while (!busy0 && gap < 20000) begin
      gap++;
      cycles(1);
    end
    lvl = level0;
    while (busy0 && blen < 20000) begin
      if (blen >= 216 && (blen - 216) % 432 == 0 && (blen - 216) / 432 < nbits) begin
        b0[(blen - 216) / 432] = txd0;
        b1[(blen - 216) / 432] = txd1;
      end
      if (!txd0) nlow++;
      blen++;
      cycles(1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; Tx_EN = 1'b1; Tx_WR = 1'b1; Tx_DATA = 8'hA5;
    baud_select = 3'd7; parity_mode = 2'b01; stop_bits = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (level0 !== 3'd0) begin n_fails++; $display("FAIL rst_write_ignored: level %0d expected 0", level0); end
    Tx_WR = 1'b0;
    reset = 1'b1;
    cycles(1);
    n_checks++; if (txd0 !== 1'b1) begin n_fails++; $display("FAIL rst_txd: got %b expected 1", txd0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fails++; $display("FAIL rst_busy: got %b expected 0", busy0); end
    n_checks++; if (empty0 !== 1'b1) begin n_fails++; $display("FAIL rst_empty: got %b expected 1", empty0); end
    n_checks++; if (full0 !== 1'b0) begin n_fails++; $display("FAIL rst_full: got %b expected 0", full0); end
    n_checks++; if (level0 !== 3'd0) begin n_fails++; $display("FAIL rst_level: got %0d expected 0", level0); end
  endtask

  task automatic test_frame_msb;
    logic [15:0] b0, b1;
    int gap, blen, nlow;
    logic [2:0] lvl;
    baud_select = 3'd7; parity_mode = 2'b01; stop_bits = 1'b0;
    do_write(8'hA5);
    capture(11, b0, b1, gap, blen, nlow, lvl);
    n_checks++; if (gap !== 2) begin n_fails++; $display("FAIL t2_latency: got %0d expected 2", gap); end
    n_checks++; if (b0[10:0] !== 11'b10101001010) begin n_fails++; $display("FAIL t2_bits_msb: got %b expected 10101001010", b0[10:0]); end
    n_checks++; if (b1[10:0] !== 11'b10101001010) begin n_fails++; $display("FAIL t2_bits_lsb: got %b expected 10101001010", b1[10:0]); end
    n_checks++; if (blen !== 4752) begin n_fails++; $display("FAIL t2_busy_len: got %0d expected 4752", blen); end
    n_checks++; if (txd0 !== 1'b1) begin n_fails++; $display("FAIL t2_idle_txd: got %b expected 1", txd0); end
  endtask

  task automatic test_lsb_parity;
    logic [15:0] b0, b1;
    int gap, blen, nlow;
    logic [2:0] lvl;
    parity_mode = 2'b10; stop_bits = 1'b1;
    do_write(8'h01);
    capture(12, b0, b1, gap, blen, nlow, lvl);
    n_checks++; if (gap !== 2) begin n_fails++; $display("FAIL t3_latency: got %0d expected 2", gap); end
    n_checks++; if (b1[11:0] !== 12'b110000000010) begin n_fails++; $display("FAIL t3_bits_lsb: got %b expected 110000000010", b1[11:0]); end
    n_checks++; if (b0[11:0] !== 12'b110100000000) begin n_fails++; $display("FAIL t3_bits_msb: got %b expected 110100000000", b0[11:0]); end
    n_checks++; if (blen !== 5184) begin n_fails++; $display("FAIL t3_busy_len: got %0d expected 5184", blen); end
  endtask

  task automatic test_fifo_full;
    logic [15:0] b0, b1;
    int gap, blen, nlow;
    logic [2:0] lvl;
    logic [7:0] wdat [6];
    logic [7:0] exp_lsb [4];
    logic [7:0] exp_msb [4];
    logic [2:0] exp_lvl [4];
    wdat    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_lsb = '{8'h22, 8'h33, 8'h44, 8'h55};
    exp_msb = '{8'h44, 8'hCC, 8'h22, 8'hAA};
    exp_lvl = '{3'd3, 3'd2, 3'd1, 3'd0};
    parity_mode = 2'b00; stop_bits = 1'b0;
    for (int k = 0; k < 6; k++) begin
      Tx_WR = 1'b1;
      Tx_DATA = wdat[k];
      cycles(1);
    end
    Tx_WR = 1'b0;
    n_checks++; if (full0 !== 1'b1) begin n_fails++; $display("FAIL t4_full: got %b expected 1", full0); end
    n_checks++; if (level0 !== 3'd4) begin n_fails++; $display("FAIL t4_level: got %0d expected 4", level0); end
    capture(0, b0, b1, gap, blen, nlow, lvl);
    n_checks++; if (blen !== 4317) begin n_fails++; $display("FAIL t4_first_rest: got %0d expected 4317", blen); end
    for (int f = 0; f < 4; f++) begin
      capture(10, b0, b1, gap, blen, nlow, lvl);
      n_checks++; if (gap !== 1) begin n_fails++; $display("FAIL t4_gap%0d: got %0d expected 1", f, gap); end
      n_checks++; if (lvl !== exp_lvl[f]) begin n_fails++; $display("FAIL t4_level%0d: got %0d expected %0d", f, lvl, exp_lvl[f]); end
      n_checks++; if (b1[9:0] !== {1'b1, exp_lsb[f], 1'b0}) begin n_fails++; $display("FAIL t4_lsb%0d: got %b expected %b", f, b1[9:0], {1'b1, exp_lsb[f], 1'b0}); end
      n_checks++; if (b0[9:0] !== {1'b1, exp_msb[f], 1'b0}) begin n_fails++; $display("FAIL t4_msb%0d: got %b expected %b", f, b0[9:0], {1'b1, exp_msb[f], 1'b0}); end
      n_checks++; if (blen !== 4320) begin n_fails++; $display("FAIL t4_len%0d: got %0d expected 4320", f, blen); end
    end
    cycles(10);
    n_checks++; if (busy0 !== 1'b0) begin n_fails++; $display("FAIL t4_no_sixth: busy %b expected 0", busy0); end
    n_checks++; if (empty0 !== 1'b1) begin n_fails++; $display("FAIL t4_empty: got %b expected 1", empty0); end
  endtask

  task automatic test_enable;
    logic [15:0] b0, b1;
    int gap, blen, nlow;
    logic [2:0] lvl;
    logic [7:0] wdat [3];
    wdat = '{8'h5A, 8'hC3, 8'h0F};
    parity_mode = 2'b00; stop_bits = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Tx_WR = 1'b1;
      Tx_DATA = wdat[k];
      cycles(1);
    end
    Tx_WR = 1'b0;
    cycles(1500);
    Tx_EN = 1'b0;
    capture(0, b0, b1, gap, blen, nlow, lvl);
    cycles(20);
    n_checks++; if (busy0 !== 1'b0) begin n_fails++; $display("FAIL t5_busy_off: got %b expected 0", busy0); end
    n_checks++; if (level0 !== 3'd2) begin n_fails++; $display("FAIL t5_level_kept: got %0d expected 2", level0); end
    n_checks++; if (txd0 !== 1'b1) begin n_fails++; $display("FAIL t5_txd_idle: got %b expected 1", txd0); end
    Tx_EN = 1'b1;
    cycles(1);
    n_checks++; if (level0 !== 3'd1) begin n_fails++; $display("FAIL t5_pop: level %0d expected 1", level0); end
    capture(10, b0, b1, gap, blen, nlow, lvl);
    n_checks++; if (gap !== 1) begin n_fails++; $display("FAIL t5_restart: got %0d expected 1", gap); end
    n_checks++; if (b1[9:0] !== {1'b1, 8'hC3, 1'b0}) begin n_fails++; $display("FAIL t5_byte2: got %b expected %b", b1[9:0], {1'b1, 8'hC3, 1'b0}); end
    capture(10, b0, b1, gap, blen, nlow, lvl);
    n_checks++; if (b1[9:0] !== {1'b1, 8'h0F, 1'b0}) begin n_fails++; $display("FAIL t5_byte3: got %b expected %b", b1[9:0], {1'b1, 8'h0F, 1'b0}); end
    n_checks++; if (blen !== 4320) begin n_fails++; $display("FAIL t5_len3: got %0d expected 4320", blen); end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break;
    logic [15:0] b0, b1;
    int gap, blen, nlow;
    logic [2:0] lvl;
    parity_mode = 2'b00; stop_bits = 1'b0;
    Tx_BREAK = 1'b1;
    cycles(1);
    Tx_BREAK = 1'b0;
    capture(0, b0, b1, gap, blen, nlow, lvl);
    n_checks++; if (gap !== 1) begin n_fails++; $display("FAIL brk_start: got %0d expected 1", gap); end
    n_checks++; if (nlow !== 4320) begin n_fails++; $display("FAIL brk_low: got %0d expected 4320", nlow); end
    n_checks++; if (blen !== 4752) begin n_fails++; $display("FAIL brk_busy: got %0d expected 4752", blen); end
    n_checks++; if (level0 !== 3'd0) begin n_fails++; $display("FAIL brk_fifo: got %0d expected 0", level0); end
  endtask
`endif

  task automatic test_reset_mid;
    parity_mode = 2'b01; stop_bits = 1'b0;
    Tx_WR = 1'b1; Tx_DATA = 8'h81;
    cycles(1);
    Tx_DATA = 8'h01;
    cycles(1);
    Tx_WR = 1'b0;
    cycles(1 + 9 * 432 + 216);
    n_checks++; if (txd0 !== 1'b0) begin n_fails++; $display("FAIL t6_parity: got %b expected 0", txd0); end
    n_checks++; if (level0 !== 3'd1) begin n_fails++; $display("FAIL t6_queued: got %0d expected 1", level0); end
    reset = 1'b0;
    cycles(1);
    n_checks++; if (txd0 !== 1'b1) begin n_fails++; $display("FAIL t6_txd: got %b expected 1", txd0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fails++; $display("FAIL t6_busy: got %b expected 0", busy0); end
    n_checks++; if (empty0 !== 1'b1) begin n_fails++; $display("FAIL t6_empty: got %b expected 1", empty0); end
    n_checks++; if (txd1 !== 1'b1) begin n_fails++; $display("FAIL t6_txd_lsb: got %b expected 1", txd1); end
    reset = 1'b1;
    cycles(5);
    n_checks++; if (busy0 !== 1'b0) begin n_fails++; $display("FAIL t6_stays_idle: got %b expected 0", busy0); end
  endtask

  initial begin
    Tx_WR = 1'b0; Tx_DATA = '0; Tx_EN = 1'b1; reset = 1'b0;
    baud_select = 3'd7; parity_mode = 2'b00; stop_bits = 1'b0;
`ifdef UART_TX_BREAK_EN
    Tx_BREAK = 1'b0;
`endif
    @(negedge clk);
    test_reset;
    test_frame_msb;
    test_lsb_parity;
    test_fifo_full;
    test_enable;
`ifdef UART_TX_BREAK_EN
    test_break;
`endif
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised successor to the codebase's fixed 8N1+parity UART transmitter. Supports configurable data width, runtime parity and stop-bit modes, selectable bit order, an integrated 16x-oversampled baud generator, and a write FIFO. Frames go out back-to-back without host pacing. Sits between the host write bus and the TxD pad; pairs with the existing receiver.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9
FIFO_DEPTH, 4, write FIFO entries; power of two, 2..64
CLK_HZ, 50000000, system clock frequency; used to derive baud divisors
LSB_FIRST, 0, 0 = MSB first (current codebase line format); 1 = LSB first (standard UART)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
Tx_EN  in  1  transmitter enable
Tx_WR  in  1  single-cycle write strobe, pushes Tx_DATA into FIFO
Tx_DATA  in  DATA_BITS  write data
baud_select  in  3  0..7 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud
parity_mode  in  2  00 none, 01 even, 10 odd, 11 forced-zero (space)
stop_bits  in  1  0 = one stop bit, 1 = two stop bits
TxD  out  1  serial line, idle high
Tx_BUSY  out  1  high while a frame is on the line
Tx_FULL  out  1  FIFO full
Tx_EMPTY  out  1  FIFO empty
Tx_LEVEL  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset==0 at a clk edge): TxD=1, Tx_BUSY=0, Tx_FULL=0, Tx_EMPTY=1, Tx_LEVEL=0; FIFO pointers, baud counter, bit counters cleared; FSM to IDLE. Reset mid-frame aborts it; TxD=1 on the next cycle.
- Baud divisor: div = (CLK_HZ + 8*rate) / (16*rate), computed at elaboration. One tick every div clocks; 16 ticks per bit. At 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
- Divider and tick counter are held cleared in IDLE and restart at frame start. Start bit is exactly 16*div clocks.
- FIFO push: Tx_WR && Tx_EN && !Tx_FULL. Writes when full or Tx_EN==0 are dropped without error.
- Pop occurs in IDLE when !Tx_EMPTY && Tx_EN. The same edge latches data, parity_mode, stop_bits and baud_select into frame registers. Mid-frame changes to these inputs take effect on the next frame.
- Simultaneous push and pop: Tx_LEVEL is unchanged. When full, a same-cycle push is still rejected.
- FSM states: IDLE -> START (1 bit, TxD=0) -> DATA (DATA_BITS bits, order per LSB_FIRST) -> PARITY (1 bit, skipped if parity_mode==00) -> STOP (1 or 2 bits, TxD=1) -> IDLE.
- Parity bit: even = XOR of data bits; odd = inverted XOR; space = 0.
- Latency: Tx_WR at edge n into an empty FIFO while idle -> pop at n+1 -> TxD falls at n+2.
- Back-to-back: if FIFO is non-empty at the end of the last stop bit, START begins on the next clock. Gap is 1 clock.
- Tx_BUSY is high from the first START cycle through the last STOP cycle, otherwise 0. TxD is registered (glitch-free).
- Tx_EN deasserted mid-frame: the current frame completes. No further pops occur; FIFO contents are retained.
- Frame length = (1 + DATA_BITS + (parity?1:0) + (stop_bits?2:1)) * 16 * div clocks.

Optional Feature:
Macro UART_TX_BREAK_EN.
- When defined: adds input Tx_BREAK (1 bit). If Tx_BREAK is high while in IDLE, the FSM enters BREAK state. TxD=0 and Tx_BUSY=1 for at least one full frame time of the latched config. BREAK ends at the first bit boundary after Tx_BREAK is low, then goes to STOP (one stop bit) -> IDLE. Tx_BREAK takes priority over a pending pop. FIFO is untouched.
- When undefined: no port, no state; behaviour exactly as above.

Test Plan:
1. Reset low 3 cycles, then high -> TxD=1, Tx_BUSY=0, Tx_EMPTY=1, Tx_LEVEL=0. Write 0xA5 during reset -> ignored, Tx_LEVEL stays 0.
2. baud_select=7, parity 01, stop 0, LSB_FIRST=0. Write 0xA5 -> TxD low 2 clocks after write. Bits sampled at 432-clk centres: 0,1,0,1,0,0,1,0,1,0,1. Tx_BUSY high for exactly 11*432=4752 clocks.
3. parity_mode=10, stop_bits=1, LSB_FIRST=1, write 0x01 -> line: 0,1,0,0,0,0,0,0,0,0(odd parity),1,1. 12 bit times.
4. Write 6 bytes in consecutive cycles while idle, FIFO_DEPTH=4 -> 5 accepted (first pops immediately). Tx_FULL asserts and the 6th is dropped. 5 frames go out with a 1-clock gap. Tx_EMPTY=1 after the 2nd pop-empty.
5. Drop Tx_EN mid-DATA with 2 bytes queued -> current frame finishes, Tx_BUSY falls, Tx_LEVEL stays 2. Re-enable -> next frame starts 1 clock later.
6. Assert reset mid-PARITY -> next cycle TxD=1, Tx_BUSY=0, FIFO empty. (With UART_TX_BREAK_EN: Tx_BREAK pulsed 1 clock at 8N1 -> TxD low ≥10*16*div clocks, then 1 stop bit.)
